// File: rtl/cpu_pkg.sv
// Shared processor definitions: datapath widths, the bubble opcode and the
// fetch-stage state encoding.
package cpu_pkg;

  localparam int WIDTH            = 16;
  localparam int INSTRUCTIONWIDTH = 24;
  localparam int OPCODEWIDTH      = 4;

  // Opcode 0000 is decoded as "no instruction"; a bubble is the all-zero word.
  localparam logic [OPCODEWIDTH-1:0]      NOP_OPCODE  = 4'b0000;
  localparam logic [INSTRUCTIONWIDTH-1:0] BUBBLE_WORD =
    {NOP_OPCODE, {(INSTRUCTIONWIDTH-OPCODEWIDTH){1'b0}}};

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  // Opcode field sits in the top bits of the instruction word.
  function automatic logic [OPCODEWIDTH-1:0] opcodeOf(
    input logic [INSTRUCTIONWIDTH-1:0] instr
  );
    return instr[INSTRUCTIONWIDTH-1 -: OPCODEWIDTH];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage (master) and the
// combinational instruction memory (slave).
interface fetch_unit_if;
  import cpu_pkg::*;

  logic [WIDTH-1:0]            imemAddr;
  logic [INSTRUCTIONWIDTH-1:0] imemData;

  modport master (output imemAddr, input  imemData);
  modport slave  (input  imemAddr, output imemData);

endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline register: holds the fetched word, its PC and a valid flag.
// flush loads a bubble (pc kept), enable loads a new instruction, otherwise hold.
module if_id_register
  import cpu_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        flush,
  input  logic [INSTRUCTIONWIDTH-1:0] instrIn,
  input  logic [WIDTH-1:0]            pcIn,
  output logic [INSTRUCTIONWIDTH-1:0] instructionD,
  output logic [WIDTH-1:0]            pcD,
  output logic                        validD
);

  // Reset clears, flush inserts a bubble, enable captures the fetched word.
  always_ff @(posedge clk) begin
    if (rst) begin
      instructionD <= BUBBLE_WORD;
      pcD          <= '0;
      validD       <= 1'b0;
    end else if (flush) begin
      instructionD <= BUBBLE_WORD;
      validD       <= 1'b0;
    end else if (enable) begin
      instructionD <= instrIn;
      pcD          <= pcIn;
      validD       <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, RUN/HALT control, saturating fetch
// counter and the IF/ID register feeding the decoder.
module fetch_unit
  import cpu_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stallF,
  input  logic                        branchTakenE,
  input  logic [WIDTH-1:0]            branchTargetE,
  input  logic [WIDTH-1:0]            endAddr,
  fetch_unit_if.master                imem,
  output logic [INSTRUCTIONWIDTH-1:0] instructionD,
  output logic [OPCODEWIDTH-1:0]      opcodeD,
  output logic [WIDTH-1:0]            pcD,
  output logic                        validD,
  output logic                        halted,
  output logic [WIDTH-1:0]            fetchCount
);

  fetch_state_t state;
  logic [WIDTH-1:0] pcF;
  logic fetchBlocked;
  logic doFetch;
  logic ifIdFlush;

  // No fetch once halted or once the PC has reached the end of the program.
  assign fetchBlocked = (state == HALT) || (pcF >= endAddr);
  assign doFetch      = !branchTakenE && !stallF && !fetchBlocked;
  // A redirect always bubbles; otherwise bubble only when not stalled and blocked.
  assign ifIdFlush    = branchTakenE || (!stallF && fetchBlocked);

  assign imem.imemAddr = pcF;
  assign opcodeD       = opcodeOf(instructionD);

  // PC, RUN/HALT state, halted flag and fetch counter, in redirect > stall > end > fetch order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      pcF        <= '0;
      halted     <= 1'b0;
      fetchCount <= '0;
    end else if (branchTakenE) begin
      pcF <= branchTargetE;
      if (branchTargetE < endAddr) begin
        state  <= RUN;
        halted <= 1'b0;
      end else begin
        state  <= HALT;
        halted <= 1'b1;
      end
    end else if (!stallF) begin
      case (state)
        RUN: begin
          if (pcF >= endAddr) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            pcF <= pcF + WIDTH'(1);
            if (fetchCount != {WIDTH{1'b1}}) begin
              fetchCount <= fetchCount + WIDTH'(1);
            end
          end
        end
        HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  if_id_register ifId (
    .clk          (clk),
    .rst          (rst),
    .enable       (doFetch),
    .flush        (ifIdFlush),
    .instrIn      (imem.imemData),
    .pcIn         (pcF),
    .instructionD (instructionD),
    .pcD          (pcD),
    .validD       (validD)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: end-of-program halt, stall, branch redirect,
// branch-over-stall, redirect out of HALT and mid-run reset.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic stallF;
  logic branchTakenE;
  logic [WIDTH-1:0] branchTargetE;
  logic [WIDTH-1:0] endAddr;
  logic [INSTRUCTIONWIDTH-1:0] instructionD;
  logic [OPCODEWIDTH-1:0] opcodeD;
  logic [WIDTH-1:0] pcD;
  logic validD;
  logic halted;
  logic [WIDTH-1:0] fetchCount;

  logic [INSTRUCTIONWIDTH-1:0] mem [0:65535];

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  fetch_unit_if imemBus ();
  assign imemBus.imemData = mem[imemBus.imemAddr];

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stallF        (stallF),
    .branchTakenE  (branchTakenE),
    .branchTargetE (branchTargetE),
    .endAddr       (endAddr),
    .imem          (imemBus.master),
    .instructionD  (instructionD),
    .opcodeD       (opcodeD),
    .pcD           (pcD),
    .validD        (validD),
    .halted        (halted),
    .fetchCount    (fetchCount)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    $display("t=%0t addr=%0h op=%0h instr=%0h pcD=%0h valid=%0b halted=%0b cnt=%0d",
             $time, imemBus.imemAddr, opcodeD, instructionD, pcD, validD, halted, fetchCount);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 24'hF00000 | 24'(i);
    mem[0] = 24'h500000;
    mem[1] = 24'h212345;
    mem[2] = 24'hA00000;
    mem[3] = 24'h700000;
    mem[5] = 24'h3C0005;
    mem[6] = 24'h4B0006;
    mem[8] = 24'h8ABCDE;

    rst = 1'b1; stallF = 1'b0; branchTakenE = 1'b0; branchTargetE = '0; endAddr = 16'd4;
    step();
    check("rst_addr",   32'(imemBus.imemAddr), 32'h0);
    check("rst_op",     32'(opcodeD), 32'h0);
    check("rst_valid",  32'(validD), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_cnt",    32'(fetchCount), 32'h0);
    rst = 1'b0;

    // Straight-line program of four instructions, then halt.
    step();
    check("seq0_op",    32'(opcodeD), 32'h5);
    check("seq0_pc",    32'(pcD), 32'h0);
    check("seq0_valid", 32'(validD), 32'h1);
    check("seq0_cnt",   32'(fetchCount), 32'h1);
    step();
    check("seq1_op",    32'(opcodeD), 32'h2);
    check("seq1_instr", 32'(instructionD), 32'h212345);
    check("seq1_cnt",   32'(fetchCount), 32'h2);
    step();
    check("seq2_op",    32'(opcodeD), 32'hA);
    step();
    check("seq3_op",    32'(opcodeD), 32'h7);
    check("seq3_cnt",   32'(fetchCount), 32'h4);
    check("seq3_halt",  32'(halted), 32'h0);
    step();
    check("end_op",     32'(opcodeD), 32'h0);
    check("end_valid",  32'(validD), 32'h0);
    check("end_halted", 32'(halted), 32'h1);
    check("end_cnt",    32'(fetchCount), 32'h4);
    check("end_addr",   32'(imemBus.imemAddr), 32'h4);
    step();
    check("halt_hold",  32'(halted), 32'h1);
    check("halt_addr",  32'(imemBus.imemAddr), 32'h4);

    // Redirect to the end address keeps the fetch halted.
    branchTakenE = 1'b1; branchTargetE = 16'd4;
    step();
    check("brEnd_halted", 32'(halted), 32'h1);
    check("brEnd_valid",  32'(validD), 32'h0);
    // Redirect inside the program leaves HALT.
    branchTargetE = 16'd1;
    step();
    check("brIn_halted", 32'(halted), 32'h0);
    check("brIn_addr",   32'(imemBus.imemAddr), 32'h1);
    check("brIn_valid",  32'(validD), 32'h0);
    branchTakenE = 1'b0;
    step();
    check("restart_instr", 32'(instructionD), 32'h212345);
    check("restart_pc",    32'(pcD), 32'h1);
    check("restart_cnt",   32'(fetchCount), 32'h5);
    check("restart_addr",  32'(imemBus.imemAddr), 32'h2);

    // Three-cycle stall at pcF=2 freezes everything.
    stallF = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_instr", 32'(instructionD), 32'h212345);
      check("stall_pc",    32'(pcD), 32'h1);
      check("stall_cnt",   32'(fetchCount), 32'h5);
      check("stall_addr",  32'(imemBus.imemAddr), 32'h2);
    end
    stallF = 1'b0;
    step();
    check("resume_instr", 32'(instructionD), 32'hA00000);
    check("resume_pc",    32'(pcD), 32'h2);
    check("resume_cnt",   32'(fetchCount), 32'h6);
    step();
    check("resume2_pc",   32'(pcD), 32'h3);
    check("resume2_cnt",  32'(fetchCount), 32'h7);

    // Fresh run with a longer program; branch from pcF=3 to 8.
    rst = 1'b1;
    step();
    rst = 1'b0; endAddr = 16'd16;
    step();
    step();
    step();
    check("pre_br_addr", 32'(imemBus.imemAddr), 32'h3);
    check("pre_br_pc",   32'(pcD), 32'h2);
    branchTakenE = 1'b1; branchTargetE = 16'd8;
    step();
    check("br_addr",  32'(imemBus.imemAddr), 32'h8);
    check("br_op",    32'(opcodeD), 32'h0);
    check("br_valid", 32'(validD), 32'h0);
    check("br_pcD",   32'(pcD), 32'h2);
    check("br_cnt",   32'(fetchCount), 32'h3);
    branchTakenE = 1'b0;
    step();
    check("br_instr", 32'(instructionD), 32'h8ABCDE);
    check("br_pc",    32'(pcD), 32'h8);
    check("br_cnt2",  32'(fetchCount), 32'h4);

    // Branch and stall together: the branch wins.
    branchTakenE = 1'b1; stallF = 1'b1; branchTargetE = 16'd5;
    step();
    check("brst_addr",  32'(imemBus.imemAddr), 32'h5);
    check("brst_valid", 32'(validD), 32'h0);
    check("brst_op",    32'(opcodeD), 32'h0);
    branchTakenE = 1'b0; stallF = 1'b0;
    step();
    check("brst_instr", 32'(instructionD), 32'h3C0005);
    check("brst_pc",    32'(pcD), 32'h5);
    check("brst_cnt",   32'(fetchCount), 32'h5);
    check("brst_addr2", 32'(imemBus.imemAddr), 32'h6);

    // Reset in the middle of a run at pcF=6.
    rst = 1'b1;
    step();
    check("mrst_addr",   32'(imemBus.imemAddr), 32'h0);
    check("mrst_op",     32'(opcodeD), 32'h0);
    check("mrst_valid",  32'(validD), 32'h0);
    check("mrst_cnt",    32'(fetchCount), 32'h0);
    check("mrst_halted", 32'(halted), 32'h0);
    rst = 1'b0;
    step();
    check("post_rst_op", 32'(opcodeD), 32'h5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
